// File: rtl/contador_cm_pkg.sv
// Shared constants for the echo-width-to-centimetre counter: FSM state
// encoding (also exported on db_estado) and the BCD digit width.
package contador_cm_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [3:0] {
        ST_INICIAL       = 4'd0,
        ST_ESPERA        = 4'd1,
        ST_CONTA         = 4'd2,
        ST_ARREDONDA     = 4'd3,
        ST_FINAL         = 4'd4,
        ST_TIMEOUT       = 4'd5,
        ST_AGUARDA_BAIXO = 4'd6
    } estado_t;

endpackage

// File: rtl/contador_bcd_sat.sv
// D-digit BCD up-counter with synchronous clear. An increment request while
// every digit is 9 leaves the value untouched and raises satura for that cycle.
module contador_bcd_sat
    import contador_cm_pkg::*;
#(
    parameter int D = 3
) (
    input  logic               clock,
    input  logic               zera,
    input  logic               conta,
    output logic [BCD_W*D-1:0] digitos,
    output logic               satura
);

    logic [BCD_W*D-1:0] digitos_q;
    logic [BCD_W*D-1:0] digitos_d;
    logic [D-1:0]       nove;
    logic               cy;

    genvar g;
    generate
        for (g = 0; g < D; g++) begin : g_nove
            assign nove[g] = (digitos_q[BCD_W*g +: BCD_W] == 4'd9);
        end
    endgenerate

    // Increment request at the all-9s ceiling is reported, not applied.
    assign satura = conta & (&nove);

    // Ripple carry: each digit wraps 9->0 and passes the carry upward.
    always_comb begin
        digitos_d = digitos_q;
        cy        = conta & ~(&nove);
        for (int i = 0; i < D; i++) begin
            if (cy) begin
                if (nove[i]) begin
                    digitos_d[BCD_W*i +: BCD_W] = 4'd0;
                end else begin
                    digitos_d[BCD_W*i +: BCD_W] = digitos_q[BCD_W*i +: BCD_W] + 4'd1;
                    cy = 1'b0;
                end
            end
        end
    end

    // Digit register; zera wins over any increment.
    always_ff @(posedge clock) begin
        if (zera) digitos_q <= '0;
        else      digitos_q <= digitos_d;
    end

    assign digitos = digitos_q;

endmodule

// File: rtl/contador_cm_param.sv
// Measures the high time of pulso in clock cycles and converts it to whole
// centimetres (R clocks per cm) in BCD, with optional round-to-nearest,
// saturation flag and timeout abort. pronto pulses once per measurement.
module contador_cm_param
    import contador_cm_pkg::*;
#(
    parameter int R          = 2941,
    parameter int N          = 12,
    parameter int D          = 3,
    parameter int TIMEOUT_CM = 400,
    parameter int TW         = 9,
    parameter int ARRED      = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pulso,
    output logic [BCD_W*D-1:0] digitos,
    output logic               pronto,
    output logic               fim,
    output logic               timeout,
    output logic               medindo,
    output logic [3:0]         db_estado
);

    estado_t       state_q, state_d;
    logic [N-1:0]  tick_q, tick_d;
    logic [TW-1:0] cm_q, cm_d;
    logic          fim_q, fim_d;
    logic          timeout_q, timeout_d;
    logic          inicia;
    logic          conta;
    logic          satura;
    logic [N:0]    tick_x2;

    // Remainder doubled so "remainder >= half a cm" needs no division.
    assign tick_x2 = {tick_q, 1'b0};

    // Next-state, counter updates and BCD increment requests.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        cm_d      = cm_q;
        timeout_d = timeout_q;
        inicia    = 1'b0;
        conta     = 1'b0;
        case (state_q)
            ST_INICIAL: begin
                // Never measure a pulse already in progress.
                state_d = pulso ? ST_AGUARDA_BAIXO : ST_ESPERA;
            end
            ST_ESPERA: begin
                if (pulso) begin
                    // Rising-edge cycle is already tick 1.
                    state_d   = ST_CONTA;
                    inicia    = 1'b1;
                    tick_d    = N'(1);
                    cm_d      = '0;
                    timeout_d = 1'b0;
                end
            end
            ST_CONTA: begin
                if (cm_q == TW'(TIMEOUT_CM)) begin
                    // Flag raised on entry so it is valid alongside pronto.
                    state_d   = ST_TIMEOUT;
                    timeout_d = 1'b1;
                end else if (!pulso) begin
                    state_d = ST_ARREDONDA;
                end else if (tick_q == N'(R - 1)) begin
                    tick_d = '0;
                    cm_d   = cm_q + TW'(1);
                    conta  = 1'b1;
                end else begin
                    tick_d = tick_q + N'(1);
                end
            end
            ST_ARREDONDA: begin
                conta   = (ARRED != 0) && (tick_x2 >= (N+1)'(R));
                state_d = ST_FINAL;
            end
            ST_FINAL: begin
                state_d = pulso ? ST_AGUARDA_BAIXO : ST_ESPERA;
            end
            ST_TIMEOUT: begin
                state_d = ST_AGUARDA_BAIXO;
            end
            ST_AGUARDA_BAIXO: begin
                if (!pulso) state_d = ST_ESPERA;
            end
            default: state_d = ST_INICIAL;
        endcase
    end

    // fim is sticky within a measurement and cleared at its start.
    assign fim_d = inicia ? 1'b0 : (fim_q | satura);

    // State, tick/cm counters and flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_INICIAL;
            tick_q    <= '0;
            cm_q      <= '0;
            fim_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            cm_q      <= cm_d;
            fim_q     <= fim_d;
            timeout_q <= timeout_d;
        end
    end

    contador_bcd_sat #(.D(D)) u_bcd (
        .clock   (clock),
        .zera    (reset | inicia),
        .conta   (conta),
        .digitos (digitos),
        .satura  (satura)
    );

    assign pronto    = (state_q == ST_FINAL) || (state_q == ST_TIMEOUT);
    assign medindo   = (state_q == ST_CONTA);
    assign db_estado = state_q;
    assign fim       = fim_q;
    assign timeout   = timeout_q;

endmodule

// File: doc/contador_cm_param.md
# contador_cm_param

Parametrised successor of the pulse-width-to-centimetre counter used in the ultrasonic ranging path. The block measures the high time of `pulso` (sensor echo), converts it to whole centimetres in a D-digit BCD register using R clocks per cm, optionally rounds the remainder to the nearest cm, and flags saturation and timeout. It sits between the echo input and the display/serial formatting logic. `pronto` is a single-cycle completion strobe.

## Interface
- `R`, 2941: clocks per cm (50 MHz, round trip); R ≥ 2
- `N`, 12: tick counter width, ceil(log2(R))
- `D`, 3: number of BCD digits, 1..6
- `TIMEOUT_CM`, 400: measurement aborted when cm count reaches this value, ≥ 1
- `TW`, 9: width of binary cm counter, ceil(log2(TIMEOUT_CM+1))
- `ARRED`, 1: 1 = round to nearest cm, 0 = truncate

- `clock`  in  1  single system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `pulso`  in  1  echo, already synchronous to `clock`
- `digitos`  out  4*D  BCD result, digit 0 in [3:0]
- `pronto`  out  1  one-cycle strobe, result valid
- `fim`  out  1  BCD saturated at all 9s during this measurement
- `timeout`  out  1  measurement aborted at TIMEOUT_CM
- `medindo`  out  1  high while in CONTA
- `db_estado`  out  4  current FSM state encoding

## Operation
- States: INICIAL=0, ESPERA=1, CONTA=2, ARREDONDA=3, FINAL=4, TIMEOUT=5, AGUARDA_BAIXO=6.
- INICIAL: entered on reset; `pulso`=0 → ESPERA, `pulso`=1 → AGUARDA_BAIXO. No partial pulse is ever measured.
- ESPERA: `pulso`=1 → CONTA. On that edge: BCD and cm counters ← 0, tick ← 1, `fim` and `timeout` ← 0. The rising-edge cycle counts as tick 1.
- CONTA, `pulso`=1: tick increments. When tick = R-1, tick ← 0, BCD +1, cm +1. Result: P high cycles give floor(P/R) cm with remainder tick = P mod R.
- CONTA, `pulso`=0 → ARREDONDA, no count on that edge.
- CONTA, cm = TIMEOUT_CM (checked before the increment) → TIMEOUT.
- ARREDONDA: if ARRED=1 and 2·tick ≥ R, BCD +1 (subject to saturation) → FINAL. `pulso` is ignored.
- FINAL: `pronto`=1 → ESPERA if `pulso`=0, else AGUARDA_BAIXO.
- TIMEOUT: `pronto`=1, `timeout` ← 1, no rounding → AGUARDA_BAIXO.
- AGUARDA_BAIXO: `pulso`=0 → ESPERA. The trailing edge does not produce a second `pronto`.
- Saturation: an increment with all digits = 9 holds the value and sets `fim`. `fim` is sticky until the next measurement start.
- `digitos`, `fim` and `timeout` hold their value after `pronto` until the next ESPERA→CONTA edge.
- The cm counter is binary, TW bits, used only for the timeout compare. It does not wrap, because timeout fires first.

## Timing
- Reset (synchronous): state INICIAL, `digitos`=0, tick=0, cm=0. `pronto`, `fim`, `timeout` and `medindo` are 0, `db_estado`=0.
- `pronto`, `medindo` and `db_estado` are decoded combinationally from the state register. All other outputs are registered.
- Latency: `pulso` first sampled low at edge e. ARREDONDA spans e..e+1, and `digitos` is final after e+1. `pronto` is high between e+1 and e+2.
- Timeout: `pronto` is high for the single cycle spent in TIMEOUT.
- Reset has priority over every transition, including mid-measurement. No `pronto` follows it.

## Structure
- Package `contador_cm_pkg`: state encoding constants (4-bit) and a BCD digit width constant (4).
- Sub-module `contador_bcd_sat #(D)`: ports `clock`, `zera`, `conta`, `digitos[4*D-1:0]`, `satura`. Synchronous clear, ripple-carry BCD increment, hold and flag at all 9s.
- Top level contains the FSM, the N-bit tick counter, the TW-bit cm counter, the rounding compare and the flags.

## Test plan
Bench parameters: R=10, N=4, D=3, TIMEOUT_CM=20, TW=5, ARRED=1 unless stated.

- Reset, then `pulso`=0 for 5 cycles → `digitos`=000, all flags 0, `db_estado` = 0 then 1.
- `pulso` high 47 cycles → `digitos`=005, `pronto` exactly one cycle, 2 edges after the fall. Same stimulus with ARRED=0 → 004.
- Rounding boundary: 44 cycles → 004; 45 cycles → 005; 40 cycles → 004; 9 cycles → 001; 4 cycles → 000.
- Timeout: `pulso` high 250 cycles → `digitos`=020, `timeout`=1, one `pronto` near cycle 201, none at the fall. A following 47-cycle pulse → 005 with `timeout`=0.
- Saturation, D=1 and TW=5: `pulso` high 120 cycles → digit 9, `fim`=1, `pronto` once.
- `pulso` high at reset release → AGUARDA_BAIXO, no `pronto`. Reset at cycle 20 of a 47-cycle pulse → outputs cleared, no `pronto`. The next 33-cycle pulse → 003.
